// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the attached
// keyboard: it holds the clock low to inhibit the device, requests to send by
// pulling data low, shifts the frame out on device-generated clock falls
// (start, 8 data bits LSB first, odd parity, stop) and then samples the
// device ACK bit. Both pins are open-collector; each *_oe = 1 means
// "drive 0", otherwise the pad is released.
//
// Optional feature macro: PS2_HOST_TX_TIMEOUT_EN
//   defined   - a watchdog aborts the frame (tx_error=1) when the device stops
//               clocking or the lines do not return idle in time.
//   undefined - no watchdog; the FSM waits on the device indefinitely.
//
// Parameters:
//   INHIBIT_CYCLES - clk cycles the clock is held low before the request
//   TIMEOUT_CYCLES - watchdog limit between device clock falls / for idle
//
// Ports:
//   clk, reset    - system clock, asynchronous active-high reset
//   tx_data       - command byte, latched on accept
//   tx_valid      - request; accepted when tx_valid && tx_ready
//   tx_ready      - high only while idle
//   tx_done       - one-cycle pulse at the end of every frame
//   tx_error      - qualifies tx_done: 1 = NACK or timeout
//   busy          - high whenever a frame is in flight
//   ps2_clk_i     - raw ps2clk pin level (asynchronous)
//   ps2_data_i    - raw ps2data pin level (asynchronous)
//   ps2_clk_oe    - 1 = pull ps2clk low
//   ps2_data_oe   - 1 = pull ps2data low
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [INH_W-1:0] r_inhCnt;
  logic [3:0]       r_bitCnt;
  logic [8:0]       r_shift;
  logic             r_nack;
  logic             r_clkOe;
  logic             r_dataOe;
  logic             r_done;
  logic             r_error;
  logic [1:0]       r_clkSync;
  logic [1:0]       r_dataSync;
  logic             r_clkPrev;
  logic             w_fe;
  logic             w_timeout;

  // Two-flop synchronizers for both pins plus one extra clock sample for
  // edge detection. Reset to 1 (idle bus level) so no false fall is seen
  // when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_i};
      r_dataSync <= {r_dataSync[0], ps2_data_i};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  assign w_fe = r_clkPrev & ~r_clkSync[1];

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdActive;

  assign w_wdActive = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT);

  // A device clock fall is progress, so it wins over an expiry landing on
  // the same cycle.
  assign w_timeout = w_wdActive && !w_fe && (r_wdog == WD_LAST);

  // Watchdog: counts cycles since entering SEND or since the last fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (!w_wdActive || w_fe) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Frame sequencer. The pin enables, done and error are registered here so
  // they change only on clk edges; the watchdog override comes last so it
  // takes priority over whatever the active state decided.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_inhCnt <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_nack   <= 1'b0;
      r_clkOe  <= 1'b0;
      r_dataOe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shift  <= {~^tx_data, tx_data};
            r_inhCnt <= '0;
            r_clkOe  <= 1'b1;
            r_dataOe <= 1'b0;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_inhCnt == INH_LAST) begin
            r_dataOe <= 1'b1;
            r_state  <= S_REQ;
          end else begin
            r_inhCnt <= r_inhCnt + 1'b1;
          end
        end
        S_REQ: begin
          // Release the clock but keep data low: that low level is the
          // start bit the device sees before its first fall.
          r_clkOe  <= 1'b0;
          r_bitCnt <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_fe) begin
            if (r_bitCnt == 4'd9) begin
              r_dataOe <= 1'b0;
              r_state  <= S_ACK;
            end else begin
              // Falls 1-8 present data bits, fall 9 the parity bit that
              // has shifted down into bit 0.
              r_dataOe <= ~r_shift[0];
              r_shift  <= {1'b0, r_shift[8:1]};
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end
        end
        S_ACK: begin
          if (w_fe) begin
            r_nack  <= r_dataSync[1];
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_clkSync[1] && r_dataSync[1]) begin
            r_done  <= 1'b1;
            r_error <= r_nack;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_timeout) begin
        r_clkOe  <= 1'b0;
        r_dataOe <= 1'b0;
        r_done   <= 1'b1;
        r_error  <= 1'b1;
        r_state  <= S_DONE;
      end
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign ps2_clk_oe  = r_clkOe;
  assign ps2_data_oe = r_dataOe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A keyboard model shares the wired-AND
// bus with the DUT, clocks frames out of it and records the bits it samples
// on its rising clock edges. Each issued command pushes its expected outcome
// onto a queue; a monitor pops and compares whenever tx_done pulses.
// The watchdog scenario is built only when PS2_HOST_TX_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH      = 20;
  localparam int TO       = 200;
  localparam int HP       = 8;
  // Pin change to registered reaction: two synchronizer flops + one register.
  localparam int SYNC_LAT = 3;

  localparam int LAT_NONE    = 0;
  localparam int LAT_IDLE    = 1;
  localparam int LAT_TIMEOUT = 2;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       err;
    bit         chkBits;
    int         latKind;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic       devClk;
  logic       devData;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         lastFall = 0;
  int         lastRelease = 0;

  logic       capStart;
  logic [7:0] capData;
  logic       capParity;
  logic       capStop;

  // Open-collector bus: either side can pull a line low.
  assign ps2_clk_i  = devClk & ~ps2_clk_oe;
  assign ps2_data_i = devData & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one command, push its expected outcome, and time the inhibit and
  // request phases that follow the accept.
  task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic err,
                               input bit expectDone, input bit chkBits, input int latKind);
    int   cnt;
    exp_t e;
    @(negedge clk);
    checkOutput("ready_before_accept", tx_ready, 1);
    if (expectDone) begin
      e.data    = data;
      e.parity  = parity;
      e.err     = err;
      e.chkBits = chkBits;
      e.latKind = latKind;
      expQ.push_back(e);
    end
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("ready_low_after_accept", tx_ready, 0);
    cnt = 0;
    while (ps2_clk_oe && !ps2_data_oe && cnt < 4 * INH) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("inhibit_cycles", cnt, INH);
    cnt = 0;
    while (ps2_clk_oe && ps2_data_oe && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("request_cycles", cnt, 1);
  endtask

  // Keyboard model. stopAfter > 0 stops clocking after that fall's rise,
  // resetAtFall > 0 asserts the DUT reset during that bit, holdLow > 0 keeps
  // the clock low that many extra cycles after the ACK fall.
  task automatic deviceFrame(input bit nack, input int stopAfter, input int resetAtFall,
                             input int holdLow);
    int waitCnt;
    capStart  = 1'bx;
    capData   = 8'hxx;
    capParity = 1'bx;
    capStop   = 1'bx;
    waitCnt = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("request_to_send_seen", (waitCnt < 500), 1);
    if (waitCnt >= 500) return;
    capStart = ps2_data_i;
    for (int f = 1; f <= 10; f++) begin
      repeat (HP) @(negedge clk);
      devClk   = 1'b0;
      lastFall = cyc;
      if (f == resetAtFall) begin
        repeat (5) @(negedge clk);
        checkOutput("data_oe_before_reset", ps2_data_oe, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("clk_oe_in_reset", ps2_clk_oe, 0);
        checkOutput("data_oe_in_reset", ps2_data_oe, 0);
        checkOutput("ready_in_reset", tx_ready, 1);
        devClk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      repeat (HP) @(negedge clk);
      if (f <= 8) capData[f-1] = ps2_data_i;
      else if (f == 9) capParity = ps2_data_i;
      else capStop = ps2_data_i;
      devClk = 1'b1;
      if (f == stopAfter) return;
    end
    repeat (HP / 2) @(negedge clk);
    devData = nack;
    repeat (HP / 2) @(negedge clk);
    devClk   = 1'b0;
    lastFall = cyc;
    repeat (HP) @(negedge clk);
    if (holdLow > 0) begin
      devData = 1'b1;
      repeat (holdLow) @(negedge clk);
      checkOutput("busy_while_clk_held", busy, 1);
      checkOutput("no_done_while_clk_held", tx_done, 0);
    end
    devClk      = 1'b1;
    devData     = 1'b1;
    lastRelease = cyc;
  endtask

  task automatic waitDrained(input int bound);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("response_arrived", expQ.size(), 0);
    if (expQ.size() != 0) expQ.delete();
  endtask

  // Monitor: compares every tx_done pulse against the oldest expectation.
  initial begin : monitor
    logic prevDone;
    exp_t e;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (prevDone) begin
        checkOutput("done_single_pulse", tx_done, 0);
        checkOutput("ready_after_done", tx_ready, 1);
        checkOutput("busy_after_done", busy, 0);
      end
      if (tx_done === 1'b1) begin
        checkOutput("done_expected", (expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("tx_error", tx_error, e.err);
          checkOutput("oe_released_at_done", {ps2_clk_oe, ps2_data_oe}, 2'b00);
          checkOutput("ready_low_at_done", tx_ready, 0);
          if (e.chkBits) begin
            checkOutput("start_bit", capStart, 0);
            checkOutput("data_bits", capData, e.data);
            checkOutput("parity_bit", capParity, e.parity);
            checkOutput("stop_bit", capStop, 1);
          end
          if (e.latKind == LAT_IDLE)
            checkOutput("done_latency_idle", cyc - lastRelease, SYNC_LAT);
          else if (e.latKind == LAT_TIMEOUT)
            checkOutput("done_latency_timeout", cyc - lastFall, TO + SYNC_LAT);
        end
      end
      prevDone = (tx_done === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    devClk   = 1'b1;
    devData  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_data_oe", ps2_data_oe, 0);
    checkOutput("reset_tx_done", tx_done, 0);
    checkOutput("reset_tx_error", tx_error, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_ready", tx_ready, 1);
    reset = 1'b0;

    $display("[TB] 0xED with ACK");
    applyStimulus(8'hED, 1'b1, 1'b0, 1'b1, 1'b1, LAT_IDLE);
    deviceFrame(1'b0, 0, 0, 0);
    waitDrained(100);

    $display("[TB] 0x01 then 0x00 back-to-back, stray tx_valid mid-frame");
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, LAT_IDLE);
    fork
      deviceFrame(1'b0, 0, 0, 0);
      begin
        repeat (30) @(negedge clk);
        checkOutput("ready_mid_frame", tx_ready, 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    waitDrained(100);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, LAT_IDLE);
    deviceFrame(1'b0, 0, 0, 0);
    waitDrained(100);

    $display("[TB] 0x55 with NACK");
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b1, 1'b1, LAT_IDLE);
    deviceFrame(1'b1, 0, 0, 0);
    waitDrained(100);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    $display("[TB] 0xF0 with device stalling after bit 3");
    applyStimulus(8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, LAT_TIMEOUT);
    deviceFrame(1'b0, 4, 0, 0);
    waitDrained(400);
`endif

    $display("[TB] reset during bit 5, then 0xFF");
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, LAT_NONE);
    deviceFrame(1'b0, 0, 6, 0);
    repeat (50) @(negedge clk);
    checkOutput("idle_after_reset", busy, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, LAT_IDLE);
    deviceFrame(1'b0, 0, 0, 0);
    waitDrained(100);

    $display("[TB] 0x80 with clock held low past ACK");
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, LAT_IDLE);
    deviceFrame(1'b0, 0, 0, 40);
    waitDrained(100);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
